// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: shared tick prescaler, per-channel 2-flop synchroniser and stability counter.
// Optional auto-repeat on held inputs is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_multi #(
   parameter int CHANNELS     = 5,
   parameter int TICK_DIV     = 100000,
   parameter int STABLE_TICKS = 4,
   parameter int CNT_W        = 3,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                tick
);

   localparam int DIV_W = $clog2(TICK_DIV);

   if (CHANNELS < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 || (2 ** CNT_W) <= (STABLE_TICKS - 1) ||
       REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("debounce_multi: illegal parameter combination");
   end

   logic [DIV_W-1:0]    div_cnt;
   logic [CHANNELS-1:0] s1;
   logic [CHANNELS-1:0] s2;
   logic [CNT_W-1:0]    cnt [CHANNELS];
   logic [CHANNELS-1:0] qualify;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         tick    <= 1'b0;
         s1      <= '0;
         s2      <= '0;
      end else begin
         div_cnt <= (div_cnt == DIV_W'(TICK_DIV - 1)) ? '0 : div_cnt + 1'b1;
         tick    <= (div_cnt == DIV_W'(TICK_DIV - 1));
         s1      <= in;
         s2      <= s1;
      end
   end

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      qualify = '0;
      for (int i = 0; i < CHANNELS; i++)
         qualify[i] = tick && (s2[i] != level[i]) && (cnt[i] == CNT_W'(STABLE_TICKS - 1));
   end

`ifdef DEBOUNCE_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0]    rep_cnt [CHANNELS];
   logic [CHANNELS-1:0] rep_armed;
   logic [CHANNELS-1:0] rep_hit;

   // The first repeat waits REPEAT_DELAY ticks; once armed, repeats come every REPEAT_RATE ticks.
   always_comb begin
      rep_hit = '0;
      for (int i = 0; i < CHANNELS; i++)
         rep_hit[i] = tick && level[i] &&
                      (rep_cnt[i] == (rep_armed[i] ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1)));
   end
`endif

   // NOTE: the counter arrays are reset like any other state because an outstanding qualification must not survive rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= '0;
         rise  <= '0;
         fall  <= '0;
         for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
`ifdef DEBOUNCE_REPEAT_EN
         rep_armed <= '0;
         for (int i = 0; i < CHANNELS; i++) rep_cnt[i] <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so the loop order cannot matter.
         for (int i = 0; i < CHANNELS; i++) begin
            rise[i] <= 1'b0;
            fall[i] <= 1'b0;
            if (s2[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (tick) begin
               if (qualify[i]) begin
                  cnt[i]   <= '0;
                  level[i] <= s2[i];
                  rise[i]  <= s2[i];
                  fall[i]  <= ~s2[i];
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end
`ifdef DEBOUNCE_REPEAT_EN
            if (!level[i]) begin
               rep_cnt[i]   <= '0;
               rep_armed[i] <= 1'b0;
            end else if (rep_hit[i]) begin
               rep_cnt[i]   <= '0;
               rep_armed[i] <= 1'b1;
               // A release qualifying on the same tick wins; rise and fall never coincide.
               if (!qualify[i]) rise[i] <= 1'b1;
            end else if (tick) begin
               rep_cnt[i] <= rep_cnt[i] + 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi (CHANNELS=2, TICK_DIV=4, STABLE_TICKS=3).
// Repeat expectations switch on DEBOUNCE_REPEAT_EN, matching the DUT build.
module tb_debounce_multi;

   logic       clk;
   logic       rst;
   logic [1:0] in;
   logic [1:0] level;
   logic [1:0] rise;
   logic [1:0] fall;
   logic       tick;

   int n_checks = 0;
   int n_errors = 0;

   int n_rise [2];
   int n_fall [2];
   int chg_cyc [2];
   int fall_cyc [2];
   int rise_cyc [2][4];
   int both_cnt;
   int tick_cyc;

   debounce_multi #(
      .CHANNELS    (2),
      .TICK_DIV    (4),
      .STABLE_TICKS(3),
      .CNT_W       (2),
      .REPEAT_DELAY(5),
      .REPEAT_RATE (2)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .in   (in),
      .level(level),
      .rise (rise),
      .fall (fall),
      .tick (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Steps n cycles, sampling at each negedge; optionally toggles in[0] every tog cycles.
   task automatic observe(input int n, input int tog);
      logic [1:0] lvl0;
      lvl0     = level;
      both_cnt = 0;
      tick_cyc = 0;
      for (int ch = 0; ch < 2; ch++) begin
         n_rise[ch]   = 0;
         n_fall[ch]   = 0;
         chg_cyc[ch]  = 0;
         fall_cyc[ch] = 0;
         for (int k = 0; k < 4; k++) rise_cyc[ch][k] = 0;
      end
      for (int c = 1; c <= n; c++) begin
         step();
         if (tick && tick_cyc == 0) tick_cyc = c;
         for (int ch = 0; ch < 2; ch++) begin
            if (chg_cyc[ch] == 0 && level[ch] != lvl0[ch]) chg_cyc[ch] = c;
            if (rise[ch]) begin
               if (n_rise[ch] < 4) rise_cyc[ch][n_rise[ch]] = c;
               n_rise[ch]++;
            end
            if (fall[ch]) begin
               if (n_fall[ch] == 0) fall_cyc[ch] = c;
               n_fall[ch]++;
            end
            if (rise[ch] && fall[ch]) both_cnt++;
         end
         if (tog > 0 && (c % tog) == 0) in[0] = ~in[0];
      end
   endtask

   initial begin
      int ticks;
      int c;

      // Reset held with both inputs high.
      rst = 1'b1;
      in  = 2'b11;
      for (int k = 0; k < 3; k++) begin
         step();
         check("reset_outputs", {level, rise, fall, tick}, 7'd0);
      end
      rst = 1'b0;
      observe(14, 0);
      check("reset_first_tick", tick_cyc, 4);
      check("reset_ch0_level_cyc", chg_cyc[0], 13);
      check("reset_ch1_level_cyc", chg_cyc[1], 13);
      check("reset_ch0_rises", n_rise[0], 1);
      check("reset_ch1_rises", n_rise[1], 1);
      check("reset_rise_with_level", rise_cyc[0][0], 13);
      check("reset_level_final", level, 2'b11);

      // Release both channels.
      in = 2'b00;
      observe(15, 0);
      check("release_latency_ok", (chg_cyc[0] >= 11 && chg_cyc[0] <= 14), 1);
      check("release_falls", n_fall[0], 1);
      check("release_no_rise", n_rise[0], 0);
      check("release_fall_with_level", fall_cyc[0], chg_cyc[0]);
      check("release_level_final", level, 2'b00);

      // Clean press on channel 0.
      in = 2'b01;
      observe(15, 0);
      check("press_latency_ok", (chg_cyc[0] >= 11 && chg_cyc[0] <= 14), 1);
      check("press_rises", n_rise[0], 1);
      check("press_rise_with_level", rise_cyc[0][0], chg_cyc[0]);
      check("press_no_fall", n_fall[0], 0);
      check("press_ch1_quiet", chg_cyc[1] + n_rise[1] + n_fall[1], 0);
      check("press_never_both", both_cnt, 0);
      check("press_level_final", level, 2'b01);

      in = 2'b00;
      observe(15, 0);
      check("release2_level", level, 2'b00);

      // Bounce every 3 cycles for 30 cycles, then hold high.
      in = 2'b01;
      observe(30, 3);
      check("bounce_no_level_change", chg_cyc[0], 0);
      check("bounce_no_pulses", n_rise[0] + n_fall[0], 0);
      in = 2'b01;
      observe(15, 0);
      check("bounce_hold_latency_ok", (chg_cyc[0] >= 11 && chg_cyc[0] <= 14), 1);
      check("bounce_hold_rises", n_rise[0], 1);
      check("bounce_hold_level", level, 2'b01);

      in = 2'b00;
      observe(15, 0);
      check("release3_level", level, 2'b00);

      // Reset two cycles after the second qualifying tick.
      in    = 2'b01;
      ticks = 0;
      c     = 0;
      while (ticks < 2 && c < 20) begin
         step();
         c++;
         if (c >= 2 && tick) ticks++;
      end
      check("rstmid_ticks_seen", ticks, 2);
      step();
      step();
      check("rstmid_not_yet_qualified", {level, rise}, 4'd0);
      rst = 1'b1;
      #1;
      check("rstmid_async_clear", {level, rise, fall, tick}, 7'd0);
      step();
      step();
      check("rstmid_held_clear", {level, rise, fall, tick}, 7'd0);
      rst = 1'b0;
      observe(14, 0);
      check("rstmid_first_tick", tick_cyc, 4);
      check("rstmid_full_requalify", chg_cyc[0], 13);
      check("rstmid_rises", n_rise[0], 1);
      check("rstmid_level", level, 2'b01);

      in = 2'b00;
      observe(15, 0);
      check("release4_level", level, 2'b00);

      // Long hold: auto-repeat when enabled, a single rise otherwise.
      in = 2'b01;
      observe(60, 0);
      check("hold_first_rise_with_level", rise_cyc[0][0], chg_cyc[0]);
      check("hold_no_fall", n_fall[0], 0);
      check("hold_never_both", both_cnt, 0);
`ifdef DEBOUNCE_REPEAT_EN
      check("hold_repeat_count_ok", (n_rise[0] >= 3), 1);
      check("hold_repeat_delay", rise_cyc[0][1] - rise_cyc[0][0], 20);
      check("hold_repeat_rate", rise_cyc[0][2] - rise_cyc[0][1], 8);
`else
      check("hold_single_rise", n_rise[0], 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
